// File: rtl/lt24_pkg.sv
// Shared constants, types and address helper for the LT24 pixel path.
package lt24_pkg;

    localparam int unsigned H_RES    = 240;
    localparam int unsigned V_RES    = 320;
    localparam int unsigned BG_W     = 60;
    localparam int unsigned SPR_DIM  = 64;
    localparam int unsigned SPR_BITS = 6;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned D_W      = 10;
    localparam int unsigned BG_AW    = 13;
    localparam int unsigned SPR_AW   = 12;
    localparam int unsigned PIX_W    = 16;

    typedef logic [PIX_W-1:0] rgb565_t;

    localparam rgb565_t KEY_COLOR = 16'hF81F;

    typedef struct packed {
        rgb565_t data;
        logic    sof;
        logic    eol;
    } pix_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Background word address: (y/4)*BG_W + x/4, with the multiply by 60 as (r*64 - r*4).
    function automatic logic [BG_AW-1:0] bg_addr_f(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        logic [BG_AW-1:0] r;
        logic [BG_AW-1:0] c;
        r = BG_AW'(y >> 2);
        c = BG_AW'(x >> 2);
        return (r << 6) - (r << 2) + c;
    endfunction

endpackage

// File: rtl/lt24_scan_counter.sv
// Row-major raster counter for one H_RES x V_RES frame with position flags.
module lt24_scan_counter
    import lt24_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last_c,
    output logic           sof_c,
    output logic           eol_c
);

    // Position flags decoded from the current count.
    assign eol_c  = (x == X_W'(H_RES - 1));
    assign last_c = eol_c && (y == Y_W'(V_RES - 1));
    assign sof_c  = (x == '0) && (y == '0);

    // Advance one pixel per enable; x wraps into the next line, the frame wraps to origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (eol_c) begin
                x <= '0;
                y <= last_c ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/lt24_frame_compositor.sv
// Frame scanner composing an upscaled background and a colour-keyed sprite into an RGB565 stream.
module lt24_frame_compositor
    import lt24_pkg::*;
(
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [X_W-1:0]    sprite_x,
    input  logic [Y_W-1:0]    sprite_y,
    output logic              busy,
    output logic              done,
    output logic [BG_AW-1:0]  background_mem_s2_address,
    output logic              background_mem_s2_chipselect,
    output logic              background_mem_s2_clken,
    output logic              background_mem_s2_write,
    input  logic [PIX_W-1:0]  background_mem_s2_readdata,
    output logic [PIX_W-1:0]  background_mem_s2_writedata,
    output logic [1:0]        background_mem_s2_byteenable,
    output logic [SPR_AW-1:0] pic_mem_s2_address,
    output logic              pic_mem_s2_chipselect,
    output logic              pic_mem_s2_clken,
    output logic              pic_mem_s2_write,
    input  logic [PIX_W-1:0]  pic_mem_s2_readdata,
    output logic [PIX_W-1:0]  pic_mem_s2_writedata,
    output logic [1:0]        pic_mem_s2_byteenable,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol
);

    state_t         state;
    state_t         state_nx;
    logic           busy_q;
    logic           done_q;
    logic           done_nx;
    logic           clear_c;
    logic [X_W-1:0] spr_x_q;
    logic [Y_W-1:0] spr_y_q;
    logic [X_W-1:0] cnt_x;
    logic [Y_W-1:0] cnt_y;
    logic           last_c;
    logic           sof_c;
    logic           eol_c;
    logic           adv_c;
    logic           issue_c;
    logic [D_W:0]   dx_c;
    logic [D_W:0]   dy_c;
    logic           in_spr_c;
    logic           s1_valid;
    logic           s1_in_spr;
    logic           s1_sof;
    logic           s1_eol;
    logic           s2_valid;
    pix_beat_t      s2_beat;
    pix_beat_t      s2_nx_c;

    // Whole pipeline moves together unless the output holds an unaccepted beat.
    assign adv_c   = ~s2_valid | pix_ready;
    assign issue_c = (state == ST_RUN) && adv_c;

    lt24_scan_counter u_scan (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .clear  (clear_c),
        .en     (issue_c),
        .x      (cnt_x),
        .y      (cnt_y),
        .last_c (last_c),
        .sof_c  (sof_c),
        .eol_c  (eol_c)
    );

    // Sprite-relative offsets; the top bit is the borrow, so no wrap past right/bottom edges.
    assign dx_c     = {1'b0, D_W'(cnt_x)} - {1'b0, D_W'(spr_x_q)};
    assign dy_c     = {1'b0, D_W'(cnt_y)} - {1'b0, D_W'(spr_y_q)};
    assign in_spr_c = ~dx_c[D_W] && ~dy_c[D_W]
                      && (dx_c[D_W-1:0] < D_W'(SPR_DIM))
                      && (dy_c[D_W-1:0] < D_W'(SPR_DIM));

    // S0: RAM address/control. clken is gated by busy so an idle block leaves the RAMs quiet.
    assign background_mem_s2_address    = bg_addr_f(cnt_x, cnt_y);
    assign background_mem_s2_chipselect = (state == ST_RUN);
    assign background_mem_s2_clken      = adv_c && busy_q;
    assign background_mem_s2_write      = 1'b0;
    assign background_mem_s2_writedata  = '0;
    assign background_mem_s2_byteenable = 2'b11;
    assign pic_mem_s2_address           = {dy_c[SPR_BITS-1:0], dx_c[SPR_BITS-1:0]};
    assign pic_mem_s2_chipselect        = (state == ST_RUN);
    assign pic_mem_s2_clken             = adv_c && busy_q;
    assign pic_mem_s2_write             = 1'b0;
    assign pic_mem_s2_writedata         = '0;
    assign pic_mem_s2_byteenable        = 2'b11;

    // FSM next-state: start only honoured in IDLE; done once S1/S2 have emptied.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        clear_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    clear_c  = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue_c && last_c) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state, status flags and sprite position latch.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            spr_x_q <= '0;
            spr_y_q <= '0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != ST_IDLE);
            done_q <= done_nx;
            if (clear_c) begin
                spr_x_q <= sprite_x;
                spr_y_q <= sprite_y;
            end
        end
    end

    // S2 compose: sprite wins where covered and not the key colour.
    always_comb begin
        s2_nx_c.data = background_mem_s2_readdata;
        s2_nx_c.sof  = s1_sof;
        s2_nx_c.eol  = s1_eol;
        if (s1_in_spr && (pic_mem_s2_readdata != KEY_COLOR)) begin
            s2_nx_c.data = pic_mem_s2_readdata;
        end
    end

    // S1/S2 pipeline registers; sideband travels alongside the RAM read.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid  <= 1'b0;
            s1_in_spr <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_beat   <= '0;
        end else if (adv_c) begin
            s1_valid  <= issue_c;
            s1_in_spr <= in_spr_c;
            s1_sof    <= sof_c;
            s1_eol    <= eol_c;
            s2_valid  <= s1_valid;
            s2_beat   <= s2_nx_c;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_valid = s2_valid;
    assign pix_data  = s2_beat.data;
    assign pix_sof   = s2_beat.sof;
    assign pix_eol   = s2_beat.eol;

endmodule

// File: tb/tb_lt24_frame_compositor.sv
// Directed bench for the LT24 frame compositor with behavioural RAM models.
module tb_lt24_frame_compositor;

    localparam int NPIX = 76800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  sprite_x = '0;
    logic [8:0]  sprite_y = '0;
    logic        busy, done;
    logic [12:0] bg_addr;
    logic        bg_cs, bg_clken, bg_write;
    logic [15:0] bg_rd = '0;
    logic [15:0] bg_wd;
    logic [1:0]  bg_be;
    logic [11:0] spr_addr;
    logic        spr_cs, spr_clken, spr_write;
    logic [15:0] spr_rd = '0;
    logic [15:0] spr_wd;
    logic [1:0]  spr_be;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol;
    logic        pix_ready = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [15:0] bg_mem  [0:4799];
    logic [15:0] spr_mem [0:4095];

    logic [15:0] cap_data [0:NPIX-1];
    bit          cap_sof  [0:NPIX-1];
    bit          cap_eol  [0:NPIX-1];

    int n_beats, done_pulses, done_cyc, last_acc, first_valid;
    int stall_err, clken_err, stalls;
    bit timed_out, busy_at0, rst_hit, rst_valid, rst_busy;

    always #5 clk = ~clk;

    lt24_frame_compositor dut (
        .clk_clk                      (clk),
        .reset_reset_n                (rst_n),
        .start                        (start),
        .sprite_x                     (sprite_x),
        .sprite_y                     (sprite_y),
        .busy                         (busy),
        .done                         (done),
        .background_mem_s2_address    (bg_addr),
        .background_mem_s2_chipselect (bg_cs),
        .background_mem_s2_clken      (bg_clken),
        .background_mem_s2_write      (bg_write),
        .background_mem_s2_readdata   (bg_rd),
        .background_mem_s2_writedata  (bg_wd),
        .background_mem_s2_byteenable (bg_be),
        .pic_mem_s2_address           (spr_addr),
        .pic_mem_s2_chipselect        (spr_cs),
        .pic_mem_s2_clken             (spr_clken),
        .pic_mem_s2_write             (spr_write),
        .pic_mem_s2_readdata          (spr_rd),
        .pic_mem_s2_writedata         (spr_wd),
        .pic_mem_s2_byteenable        (spr_be),
        .pix_data                     (pix_data),
        .pix_valid                    (pix_valid),
        .pix_ready                    (pix_ready),
        .pix_sof                      (pix_sof),
        .pix_eol                      (pix_eol)
    );

    // Synchronous RAMs: one-cycle read latency, output held while clken is low.
    always @(posedge clk) begin
        if (bg_clken)  bg_rd  <= (bg_addr < 13'd4800) ? bg_mem[bg_addr] : 16'h0;
        if (spr_clken) spr_rd <= spr_mem[spr_addr];
    end

    // Reference pixel: background word n holds n; sprite word a holds 16'h1000|a or the key.
    function automatic logic [15:0] model_pix(input int x, input int y, input int sx,
                                              input int sy, input bit key);
        int dx, dy;
        logic [15:0] s;
        dx = x - sx;
        dy = y - sy;
        if (dx >= 0 && dy >= 0 && dx < 64 && dy < 64) begin
            s = key ? 16'hF81F : (16'h1000 | 16'(dy * 64 + dx));
            if (s != 16'hF81F) return s;
        end
        return 16'((y / 4) * 60 + x / 4);
    endfunction

    task automatic load_mems(input bit key);
        for (int i = 0; i < 4800; i++) bg_mem[i] = 16'(i);
        for (int i = 0; i < 4096; i++) spr_mem[i] = key ? 16'hF81F : (16'h1000 | 16'(i));
    endtask

    // Starts a frame and records accepted beats, stall behaviour and done timing.
    task automatic run_frame(input int sx, input int sy, input int ready_pct,
                             input int reset_at, input int repulse_at, input int limit);
        int cyc;
        bit pend, pv;
        logic [15:0] pd;
        logic ps, pe;
        n_beats = 0; done_pulses = 0; done_cyc = -1; last_acc = -1; first_valid = -1;
        stall_err = 0; clken_err = 0; stalls = 0; timed_out = 0; busy_at0 = 0;
        rst_hit = 0; rst_valid = 1; rst_busy = 1;
        pend = 0; pd = '0; ps = 0; pe = 0;
        @(negedge clk);
        sprite_x = 8'(sx); sprite_y = 9'(sy); start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        forever begin
            if (cyc >= limit) begin timed_out = 1; break; end
            if (cyc == repulse_at) begin
                start = 1'b1; sprite_x = 8'(sx + 37); sprite_y = 9'(sy / 2);
            end else begin
                start = 1'b0;
            end
            pix_ready = (($urandom % 100) < 32'(ready_pct));
            #1;
            if (cyc == 0) busy_at0 = busy;
            pv = pix_valid;
            if (reset_at >= 0 && n_beats == reset_at && pv) begin
                rst_n = 1'b0;
                #1;
                rst_hit = 1; rst_valid = pix_valid; rst_busy = busy;
                break;
            end
            if (pend && (pix_data !== pd || pix_sof !== ps || pix_eol !== pe)) stall_err++;
            pend = 0;
            if (pv && first_valid < 0) first_valid = cyc;
            if (pv && !pix_ready) begin
                stalls++;
                if (bg_clken || spr_clken) clken_err++;
                pend = 1; pd = pix_data; ps = pix_sof; pe = pix_eol;
            end
            if (pv && pix_ready) begin
                if (n_beats < NPIX) begin
                    cap_data[n_beats] = pix_data;
                    cap_sof[n_beats]  = pix_sof;
                    cap_eol[n_beats]  = pix_eol;
                end
                n_beats++;
                last_acc = cyc;
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        checks++; if (pix_data !== 16'h0 || pix_sof !== 1'b0 || pix_eol !== 1'b0) begin fails++; $display("FAIL reset_pix: got %h %b %b want 0 0 0", pix_data, pix_sof, pix_eol); end
        checks++; if (bg_addr !== 13'd0 || spr_addr !== 12'd0) begin fails++; $display("FAIL reset_addr: got %0d %0d want 0 0", bg_addr, spr_addr); end
        checks++; if ({bg_cs, bg_clken, bg_write, spr_cs, spr_clken, spr_write} !== 6'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 000000", {bg_cs, bg_clken, bg_write, spr_cs, spr_clken, spr_write}); end
        checks++; if (bg_wd !== 16'h0 || spr_wd !== 16'h0) begin fails++; $display("FAIL reset_wdata: got %h %h want 0 0", bg_wd, spr_wd); end
        checks++; if (bg_be !== 2'b11 || spr_be !== 2'b11) begin fails++; $display("FAIL reset_be: got %b %b want 11 11", bg_be, spr_be); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full frame, sprite at (100,200), ready held high, start re-pulsed mid-frame.
    task automatic test_frame_sprite();
        int err, sofs, eols, bad_eol, idx;
        load_mems(1'b0);
        run_frame(100, 200, 100, -1, 5000, 80000);
        checks++; if (timed_out !== 1'b0) begin fails++; $display("FAIL frame_timeout: got %b want 0", timed_out); end
        checks++; if (busy_at0 !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b want 1", busy_at0); end
        checks++; if (n_beats != NPIX) begin fails++; $display("FAIL beat_count: got %0d want %0d", n_beats, NPIX); end
        checks++; if (first_valid != 2) begin fails++; $display("FAIL first_latency: got %0d want 2", first_valid); end
        checks++; if (last_acc - first_valid != NPIX - 1) begin fails++; $display("FAIL no_bubbles: got span %0d want %0d", last_acc - first_valid, NPIX - 1); end
        checks++; if (done_cyc != last_acc + 2) begin fails++; $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_acc + 2); end
        checks++; if (done_pulses != 1) begin fails++; $display("FAIL done_width: got %0d want 1", done_pulses); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done: got %b want 0", busy); end
        checks++; if (cap_data[6*240+9] !== 16'd62) begin fails++; $display("FAIL pix_9_6: got %h want 003e", cap_data[6*240+9]); end
        checks++; if (cap_data[200*240+100] !== 16'h1000) begin fails++; $display("FAIL pix_100_200: got %h want 1000", cap_data[200*240+100]); end
        checks++; if (cap_data[263*240+163] !== 16'h1FFF) begin fails++; $display("FAIL pix_163_263: got %h want 1fff", cap_data[263*240+163]); end
        checks++; if (cap_data[263*240+164] !== 16'd3941) begin fails++; $display("FAIL pix_164_263: got %0d want 3941", cap_data[263*240+164]); end
        checks++; if (cap_data[200*240+99] !== 16'd3024) begin fails++; $display("FAIL pix_99_200: got %0d want 3024", cap_data[200*240+99]); end
        err = 0; idx = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (cap_data[i] !== model_pix(i % 240, i / 240, 100, 200, 1'b0)) begin
                err++;
                if (idx < 0) idx = i;
            end
        end
        checks++; if (err != 0) begin fails++; $display("FAIL frame_b_pixels: got %0d bad (first idx %0d) want 0", err, idx); end
        sofs = 0; eols = 0; bad_eol = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (cap_sof[i]) sofs++;
            if (cap_eol[i]) begin eols++; if (i % 240 != 239) bad_eol++; end
        end
        checks++; if (sofs != 1 || cap_sof[0] !== 1'b1) begin fails++; $display("FAIL sof_count: got %0d (first %b) want 1 at beat 0", sofs, cap_sof[0]); end
        checks++; if (eols != 320) begin fails++; $display("FAIL eol_count: got %0d want 320", eols); end
        checks++; if (bad_eol != 0) begin fails++; $display("FAIL eol_position: got %0d misplaced want 0", bad_eol); end
    endtask

    // Full frame with the sprite hanging off the bottom-right corner.
    task automatic test_clip();
        int err;
        load_mems(1'b0);
        run_frame(200, 300, 100, -1, -1, 80000);
        checks++; if (timed_out !== 1'b0 || n_beats != NPIX) begin fails++; $display("FAIL clip_frame: got timeout %b beats %0d want 0 %0d", timed_out, n_beats, NPIX); end
        checks++; if (cap_data[319*240+239] !== 16'h14E7) begin fails++; $display("FAIL pix_239_319: got %h want 14e7", cap_data[319*240+239]); end
        checks++; if (cap_data[300*240+200] !== 16'h1000) begin fails++; $display("FAIL pix_200_300: got %h want 1000", cap_data[300*240+200]); end
        checks++; if (cap_data[300*240+0] !== 16'd4500) begin fails++; $display("FAIL pix_0_300_nowrap: got %0d want 4500", cap_data[300*240]); end
        checks++; if (cap_data[300*240+199] !== 16'd4549) begin fails++; $display("FAIL pix_199_300: got %0d want 4549", cap_data[300*240+199]); end
        err = 0;
        for (int i = 0; i < NPIX; i++)
            if (cap_data[i] !== model_pix(i % 240, i / 240, 200, 300, 1'b0)) err++;
        checks++; if (err != 0) begin fails++; $display("FAIL frame_c_pixels: got %0d bad want 0", err); end
        checks++; if (done_pulses != 1) begin fails++; $display("FAIL clip_done: got %0d want 1", done_pulses); end
    endtask

    // Random 30% ready with an all-key sprite at the origin, then reset at beat 1000.
    task automatic test_stall_reset();
        int err;
        load_mems(1'b1);
        run_frame(0, 0, 30, 1000, -1, 20000);
        checks++; if (rst_hit !== 1'b1) begin fails++; $display("FAIL stall_reach_1000: got beats %0d want 1000", n_beats); end
        checks++; if (stalls <= 0) begin fails++; $display("FAIL stall_seen: got %0d stalls want >0", stalls); end
        checks++; if (stall_err != 0) begin fails++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
        checks++; if (clken_err != 0) begin fails++; $display("FAIL stall_clken: got %0d high want 0", clken_err); end
        err = 0;
        for (int i = 0; i < 1000; i++)
            if (cap_data[i] !== model_pix(i % 240, i / 240, 0, 0, 1'b1)) err++;
        checks++; if (err != 0) begin fails++; $display("FAIL stall_pixels: got %0d bad want 0", err); end
        checks++; if (rst_valid !== 1'b0 || rst_busy !== 1'b0) begin fails++; $display("FAIL reset_midframe: got valid %b busy %b want 0 0", rst_valid, rst_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        err = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || pix_valid || busy) err++;
        end
        checks++; if (err != 0) begin fails++; $display("FAIL no_partial_done: got %0d active cycles want 0", err); end
    endtask

    initial begin
        test_reset();
        test_stall_reset();
        test_frame_sprite();
        test_clip();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
